// File: rtl/taxi_trip_if.sv
// Bus between the taxi trip sequencer and its environment: 1 Hz tick, buttons, trip outputs.
// The optional night input exists only when NIGHT_RATE_EN is defined.
interface taxi_trip_if #(
  parameter int DIST_W = 8,
  parameter int WAIT_W = 8,
  parameter int FARE_W = 16
) ();
  logic              tick_1hz;
  logic              btn_start;
  logic              btn_pause;
  logic              btn_stop;
`ifdef NIGHT_RATE_EN
  logic              night;
`endif
  logic [1:0]        state;
  logic [DIST_W-1:0] dist_km;
  logic [WAIT_W-1:0] wait_min;
  logic [FARE_W-1:0] fare;
  logic              trip_done;

  modport master (
    output tick_1hz, btn_start, btn_pause, btn_stop,
`ifdef NIGHT_RATE_EN
    output night,
`endif
    input  state, dist_km, wait_min, fare, trip_done
  );

  modport slave (
    input  tick_1hz, btn_start, btn_pause, btn_stop,
`ifdef NIGHT_RATE_EN
    input  night,
`endif
    output state, dist_km, wait_min, fare, trip_done
  );
endinterface

// File: rtl/taxi_trip_ctrl.sv
// Taxi trip sequencer: IDLE/MOVE/WAIT FSM, distance/wait accumulation and saturating fare.
// Optional feature macro: NIGHT_RATE_EN (adds the night input and 1.5x per-km rate).
module taxi_trip_ctrl #(
  parameter int SEC_PER_KM = 10,
  parameter int WAIT_UNIT  = 60,
  parameter int BASE_FARE  = 100,
  parameter int BASE_DIST  = 3,
  parameter int PER_KM     = 20,
  parameter int PER_WAIT   = 10,
  parameter int FARE_W     = 16,
  parameter int DIST_W     = 8,
  parameter int WAIT_W     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  taxi_trip_if.slave  bus
);

  localparam int SEC_W   = (SEC_PER_KM > 1) ? $clog2(SEC_PER_KM) : 1;
  localparam int WCNT_W  = (WAIT_UNIT > 1) ? $clog2(WAIT_UNIT) : 1;
  localparam int NIGHT_KM = PER_KM + PER_KM / 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MOVE = 2'b01,
    WAIT = 2'b11
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                w_start_trip;
  logic                w_stop_trip;
  logic [SEC_W-1:0]    r_sec_cnt;
  logic [WCNT_W-1:0]   r_wait_cnt;
  logic [DIST_W-1:0]   r_dist_km;
  logic [WAIT_W-1:0]   r_wait_min;
  logic [FARE_W-1:0]   r_fare;
  logic                r_stop_seen;
  logic                r_trip_done;

  logic                w_km_tick;
  logic                w_min_tick;
  logic                w_fare_add;
  logic [FARE_W-1:0]   w_fare_inc;
  logic [FARE_W-1:0]   w_km_rate;
  logic [FARE_W:0]     w_fare_sum;
  logic [FARE_W-1:0]   w_fare_next;

  // NOTE: every signal is given a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    w_start_trip = 1'b0;
    w_stop_trip  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.btn_start) begin
          w_next_state = MOVE;
          w_start_trip = 1'b1;
        end
      end
      MOVE: begin
        if (bus.btn_stop) begin
          w_next_state = IDLE;
          w_stop_trip  = 1'b1;
        end else if (bus.btn_pause) begin
          w_next_state = WAIT;
        end
      end
      WAIT: begin
        if (bus.btn_stop) begin
          w_next_state = IDLE;
          w_stop_trip  = 1'b1;
        end else if (bus.btn_start) begin
          w_next_state = MOVE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Ticks are credited to the current state, so a tick on a transition edge belongs to the state being left.
  assign w_km_tick  = (r_state == MOVE) && bus.tick_1hz && (r_sec_cnt == SEC_W'(SEC_PER_KM - 1));
  assign w_min_tick = (r_state == WAIT) && bus.tick_1hz && (r_wait_cnt == WCNT_W'(WAIT_UNIT - 1));

`ifdef NIGHT_RATE_EN
  assign w_km_rate = bus.night ? FARE_W'(NIGHT_KM) : FARE_W'(PER_KM);
`else
  assign w_km_rate = FARE_W'(PER_KM);
`endif

  always_comb begin
    w_fare_add = 1'b0;
    w_fare_inc = '0;
    if (w_km_tick && !(&r_dist_km) && (int'(r_dist_km) >= BASE_DIST)) begin
      w_fare_add = 1'b1;
      w_fare_inc = w_km_rate;
    end else if (w_min_tick && !(&r_wait_min)) begin
      w_fare_add = 1'b1;
      w_fare_inc = FARE_W'(PER_WAIT);
    end
  end

  // One extra sum bit catches the carry so the fare clamps at all-ones instead of wrapping.
  assign w_fare_sum  = {1'b0, r_fare} + {1'b0, w_fare_inc};
  assign w_fare_next = w_fare_sum[FARE_W] ? '1 : w_fare_sum[FARE_W-1:0];

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sec_cnt   <= '0;
      r_wait_cnt  <= '0;
      r_dist_km   <= '0;
      r_wait_min  <= '0;
      r_fare      <= '0;
      r_stop_seen <= 1'b0;
      r_trip_done <= 1'b0;
    end else begin
      r_stop_seen <= w_stop_trip;
      r_trip_done <= r_stop_seen;
      if (w_start_trip) begin
        r_sec_cnt  <= '0;
        r_wait_cnt <= '0;
        r_dist_km  <= '0;
        r_wait_min <= '0;
        r_fare     <= FARE_W'(BASE_FARE);
      end else begin
        if (r_state == MOVE && bus.tick_1hz) begin
          if (w_km_tick) begin
            r_sec_cnt <= '0;
            if (!(&r_dist_km)) r_dist_km <= r_dist_km + 1'b1;
          end else begin
            r_sec_cnt <= r_sec_cnt + 1'b1;
          end
        end
        if (r_state == WAIT && bus.tick_1hz) begin
          if (w_min_tick) begin
            r_wait_cnt <= '0;
            if (!(&r_wait_min)) r_wait_min <= r_wait_min + 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        if (w_fare_add) r_fare <= w_fare_next;
      end
    end
  end

  assign bus.state     = r_state;
  assign bus.dist_km   = r_dist_km;
  assign bus.wait_min  = r_wait_min;
  assign bus.fare      = r_fare;
  assign bus.trip_done = r_trip_done;

endmodule

// File: tb/tb_taxi_trip_ctrl.sv
// Directed self-checking bench for taxi_trip_ctrl: default-parameter instance plus a small
// 8-bit-fare instance for fare saturation. Honours NIGHT_RATE_EN when defined.
module tb_taxi_trip_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  taxi_trip_if #(.DIST_W(8), .WAIT_W(8), .FARE_W(16)) bus ();
  taxi_trip_if #(.DIST_W(8), .WAIT_W(8), .FARE_W(8))  bus2 ();

  taxi_trip_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  taxi_trip_ctrl #(
    .SEC_PER_KM(2), .WAIT_UNIT(60), .BASE_FARE(250), .BASE_DIST(0),
    .PER_KM(20), .PER_WAIT(10), .FARE_W(8), .DIST_W(8), .WAIT_W(8)
  ) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic step(input logic tk, input logic st, input logic pa, input logic sp);
    @(negedge clk);
    bus.tick_1hz  = tk;
    bus.btn_start = st;
    bus.btn_pause = pa;
    bus.btn_stop  = sp;
    @(posedge clk);
    #1;
    bus.tick_1hz  = 1'b0;
    bus.btn_start = 1'b0;
    bus.btn_pause = 1'b0;
    bus.btn_stop  = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step2(input logic tk, input logic st);
    @(negedge clk);
    bus2.tick_1hz  = tk;
    bus2.btn_start = st;
    @(posedge clk);
    #1;
    bus2.tick_1hz  = 1'b0;
    bus2.btn_start = 1'b0;
  endtask

  int exp_night_fare;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus.tick_1hz = 0;  bus.btn_start = 0;  bus.btn_pause = 0;  bus.btn_stop = 0;
    bus2.tick_1hz = 0; bus2.btn_start = 0; bus2.btn_pause = 0; bus2.btn_stop = 0;
`ifdef NIGHT_RATE_EN
    bus.night  = 1'b0;
    bus2.night = 1'b0;
    exp_night_fare = 140;
`else
    exp_night_fare = 130;
`endif
    rst_n = 1'b0;
    #3;
    check("rst_state", bus.state, 0);
    check("rst_dist", bus.dist_km, 0);
    check("rst_wait", bus.wait_min, 0);
    check("rst_fare", bus.fare, 0);
    check("rst_done", bus.trip_done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Trip 1: start, base distance, first billable km.
    step(0, 1, 0, 0);
    check("start_state", bus.state, 1);
    check("start_fare", bus.fare, 100);
    check("start_dist", bus.dist_km, 0);
    ticks(30);
    check("km3_dist", bus.dist_km, 3);
    check("km3_fare", bus.fare, 100);
    ticks(10);
    check("km4_dist", bus.dist_km, 4);
    check("km4_fare", bus.fare, 120);

    // Partial km, pause, two wait minutes, resume.
    ticks(5);
    step(0, 0, 1, 0);
    check("pause_state", bus.state, 3);
    ticks(120);
    check("wait2_min", bus.wait_min, 2);
    check("wait2_fare", bus.fare, 140);
    check("wait2_dist", bus.dist_km, 4);
    step(0, 1, 0, 0);
    check("resume_state", bus.state, 1);
    ticks(4);
    check("partial_dist", bus.dist_km, 4);
    ticks(1);
    check("carry_dist", bus.dist_km, 5);
    check("carry_fare", bus.fare, 160);

    // Stop+pause together with a tick: stop wins, tick credited to MOVE.
    ticks(9);
    step(1, 0, 1, 1);
    check("stop_state", bus.state, 0);
    check("stop_tick_dist", bus.dist_km, 6);
    check("stop_tick_fare", bus.fare, 180);
    step(0, 0, 0, 0);
    check("done_pulse", bus.trip_done, 1);
    check("hold_dist", bus.dist_km, 6);
    check("hold_wait", bus.wait_min, 2);
    check("hold_fare", bus.fare, 180);
    step(0, 0, 0, 0);
    check("done_once", bus.trip_done, 0);

    // Buttons and ticks in IDLE.
    step(0, 0, 1, 0);
    check("idle_pause", bus.state, 0);
    step(0, 0, 0, 1);
    check("idle_stop", bus.state, 0);
    step(0, 0, 0, 0);
    check("idle_no_done", bus.trip_done, 0);
    ticks(10);
    check("idle_tick_dist", bus.dist_km, 6);

    // Trip 2: fresh start, ignored start in MOVE, tick on resume edge credited to WAIT.
    step(0, 1, 0, 0);
    check("t2_fare", bus.fare, 100);
    check("t2_dist", bus.dist_km, 0);
    check("t2_wait", bus.wait_min, 0);
    step(0, 1, 0, 0);
    check("move_start_ign", bus.state, 1);
    ticks(9);
    step(0, 0, 1, 0);
    ticks(59);
    check("wait_pre_min", bus.wait_min, 0);
    step(1, 1, 0, 0);
    check("resume_tick_state", bus.state, 1);
    check("resume_tick_min", bus.wait_min, 1);
    check("resume_tick_fare", bus.fare, 110);
`ifdef NIGHT_RATE_EN
    bus.night = 1'b1;
`endif
    ticks(31);
    check("t2_dist4", bus.dist_km, 4);
    check("t2_fare4", bus.fare, exp_night_fare);

    // Asynchronous reset mid-MOVE.
    ticks(3);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_state", bus.state, 0);
    check("arst_dist", bus.dist_km, 0);
    check("arst_fare", bus.fare, 0);
    check("arst_wait", bus.wait_min, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("arst_no_done", bus.trip_done, 0);
    check("arst_idle", bus.state, 0);

    // Fare saturation on the 8-bit instance.
    step2(0, 1);
    check("sat_start", bus2.fare, 250);
    step2(1, 0);
    step2(1, 0);
    check("sat_km1_dist", bus2.dist_km, 1);
    check("sat_km1_fare", bus2.fare, 255);
    for (int i = 0; i < 4; i++) step2(1, 0);
    check("sat_km3_dist", bus2.dist_km, 3);
    check("sat_km3_fare", bus2.fare, 255);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
